// File: rtl/sipo_deframer.sv
// Serial-in parallel-out deframer: rebuilds MSB-first WIDTH-bit words from a framed bit stream.
// Optional even-parity bit and parity_err output are enabled by defining SIPO_DEFRAMER_PARITY_EN.
module sipo_deframer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_valid,
    input  logic             frame_start,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err,
`ifdef SIPO_DEFRAMER_PARITY_EN
    output logic             parity_err,
`endif
    output logic             dbg_state
);

`ifdef SIPO_DEFRAMER_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME_BITS = WIDTH + PAR_BITS;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] DATA_CNT  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] FIRST_CNT = CNT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] count;

    logic [WIDTH-1:0] first_word;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] next_word;
    logic             last_bit;
    logic             can_load;
`ifdef SIPO_DEFRAMER_PARITY_EN
    logic             next_perr;
`endif

    // Output handshake: a word transfers on any cycle with data_valid & data_ready;
    // data_out/parity_err hold steady while data_valid=1 and no transfer occurs.
    always_comb begin
        first_word = {{(WIDTH-1){1'b0}}, serial_in};
        shifted    = {shreg[WIDTH-2:0], serial_in};
        last_bit   = (count == LAST_CNT);
        can_load   = !data_valid || data_ready;
`ifdef SIPO_DEFRAMER_PARITY_EN
        // Last sampled bit is the parity bit; the data word is already complete in shreg.
        next_word  = shreg;
        next_perr  = (^shreg) ^ serial_in;
`else
        next_word  = shifted;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shreg      <= '0;
            count      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
`ifdef SIPO_DEFRAMER_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;

            // Pop; a completing frame below overrides this with a same-edge load.
            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
`ifdef SIPO_DEFRAMER_PARITY_EN
                parity_err <= 1'b0;
`endif
            end

            if (bit_valid) begin
                case (state)
                    IDLE: begin
                        if (frame_start) begin
                            shreg <= first_word;
                            count <= FIRST_CNT;
                            state <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (frame_start) begin
                            frame_err <= 1'b1;
                            shreg     <= first_word;
                            count     <= FIRST_CNT;
                        end else if (last_bit) begin
                            state <= IDLE;
                            count <= '0;
                            if (can_load) begin
                                data_out   <= next_word;
                                data_valid <= 1'b1;
`ifdef SIPO_DEFRAMER_PARITY_EN
                                parity_err <= next_perr;
`endif
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            if (count < DATA_CNT) begin
                                shreg <= shifted;
                            end
                            count <= count + FIRST_CNT;
                        end
                    end
                endcase
            end
        end
    end

    assign busy      = (state == SHIFT);
    assign dbg_state = (state == SHIFT);

endmodule

// File: tb/tb_sipo_deframer.sv
// Bench for sipo_deframer: queue-based frame model checked every cycle plus directed literal checks.
module tb_sipo_deframer;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;
`ifdef SIPO_DEFRAMER_PARITY_EN
    localparam int NB = WIDTH + 1;
`else
    localparam int NB = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             bit_valid = 1'b0;
    logic             frame_start = 1'b0;
    logic             serial_in = 1'b0;
    logic             data_ready = 1'b0;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             busy;
    logic             overrun;
    logic             frame_err;
    logic             dbg_state;
    logic             parity_err_w;

    int n_cmp  = 0;
    int n_fail = 0;

    sipo_deframer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bit_valid   (bit_valid),
        .frame_start (frame_start),
        .serial_in   (serial_in),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .busy        (busy),
        .overrun     (overrun),
        .frame_err   (frame_err),
`ifdef SIPO_DEFRAMER_PARITY_EN
        .parity_err  (parity_err_w),
`endif
        .dbg_state   (dbg_state)
    );

`ifndef SIPO_DEFRAMER_PARITY_EN
    assign parity_err_w = 1'b0;
`endif

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // behavioural model: bits of the open frame, plus the output register contents
    logic       exp_q[$];
    logic       m_in_frame = 1'b0;
    logic [3:0] m_data     = '0;
    logic       m_valid    = 1'b0;
    logic       m_perr     = 1'b0;
    logic       m_ovr      = 1'b0;
    logic       m_ferr     = 1'b0;

    task automatic model_reset();
        exp_q.delete();
        m_in_frame = 1'b0;
        m_data = '0;
        m_valid = 1'b0;
        m_perr = 1'b0;
        m_ovr = 1'b0;
        m_ferr = 1'b0;
    endtask

    task automatic model_step();
        logic loaded;
        int   word;
        logic par;
        loaded = 1'b0;
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        if (bit_valid) begin
            if (frame_start) begin
                if (m_in_frame) m_ferr = 1'b1;
                exp_q.delete();
                exp_q.push_back(serial_in);
                m_in_frame = 1'b1;
            end else if (m_in_frame) begin
                exp_q.push_back(serial_in);
                if (exp_q.size() == NB) begin
                    word = 0;
                    par  = 1'b0;
                    for (int i = 0; i < NB; i++) par = par ^ exp_q[i];
                    for (int i = 0; i < WIDTH; i++) word = word * 2 + int'(exp_q[i]);
                    if (!m_valid || data_ready) begin
                        m_data = word[3:0];
                        m_perr = par;
                        loaded = 1'b1;
                    end else begin
                        m_ovr = 1'b1;
                    end
                    exp_q.delete();
                    m_in_frame = 1'b0;
                end
            end
        end
        if (loaded) m_valid = 1'b1;
        else if (m_valid && data_ready) begin
            m_valid = 1'b0;
            m_perr  = 1'b0;
        end
    endtask

    // scoreboard compare: every cycle, 1 time unit after the edge
    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else model_step();
        #1;
        chk("data_out", 32'(data_out), 32'(m_data));
        chk("data_valid", 32'(data_valid), 32'(m_valid));
        chk("busy", 32'(busy), 32'(m_in_frame));
        chk("dbg_state", 32'(dbg_state), 32'(m_in_frame));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("frame_err", 32'(frame_err), 32'(m_ferr));
`ifdef SIPO_DEFRAMER_PARITY_EN
        chk("parity_err", 32'(parity_err_w), 32'(m_perr));
`endif
    end

    // driver tasks (inputs change on the falling edge)
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bit_valid = 1'b0;
            frame_start = 1'b0;
        end
    endtask

    task automatic send_bit(input logic fs, input logic b);
        @(negedge clk);
        bit_valid = 1'b1;
        frame_start = fs;
        serial_in = b;
    endtask

    task automatic send_word(input logic [3:0] w, input int gap_max, input logic par,
                             input logic ready_last);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i != WIDTH - 1 && gap_max > 0) idle($urandom_range(0, gap_max));
`ifndef SIPO_DEFRAMER_PARITY_EN
            if (i == 0 && ready_last) data_ready = 1'b1;
`endif
            send_bit(i == WIDTH - 1, w[i]);
            if (i != WIDTH - 1) chk("busy_mid_frame", 32'(busy), 32'd1);
        end
`ifdef SIPO_DEFRAMER_PARITY_EN
        if (ready_last) data_ready = 1'b1;
        send_bit(1'b0, par);
`else
        if (par) begin end
`endif
    endtask

    initial begin
        // power-on reset
        repeat (3) @(negedge clk);
        chk("reset_valid", 32'(data_valid), 32'd0);
        rst = 1'b1;
        idle(2);

        // reset held 3 cycles mid-frame discards it
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        bit_valid = 1'b0;
        frame_start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_outputs", {data_out, data_valid, busy, overrun, frame_err, parity_err_w},
                32'd0);
        end
        rst = 1'b1;
        idle(1);
        chk("rst_busy_after", 32'(busy), 32'd0);

        // 4'hB with ready high: valid for exactly one cycle
        data_ready = 1'b1;
        send_word(4'hB, 0, 1'b1, 1'b0);
        idle(1);
        chk("b_data", 32'(data_out), 32'hB);
        chk("b_valid", 32'(data_valid), 32'd1);
        chk("b_busy_done", 32'(busy), 32'd0);
        idle(1);
        chk("b_valid_gone", 32'(data_valid), 32'd0);

        // 4'h9 with random gaps between bits
        send_word(4'h9, 3, 1'b0, 1'b0);
        idle(1);
        chk("9_data", 32'(data_out), 32'h9);
        chk("9_busy_done", 32'(busy), 32'd0);
        idle(2);

        // overrun: 4'h3 held, 4'hC dropped
        data_ready = 1'b0;
        send_word(4'h3, 0, 1'b0, 1'b0);
        send_word(4'hC, 1, 1'b0, 1'b0);
        idle(1);
        chk("ovr_pulse", 32'(overrun), 32'd1);
        chk("ovr_data_kept", 32'(data_out), 32'h3);
        idle(1);
        chk("ovr_one_cycle", 32'(overrun), 32'd0);
        data_ready = 1'b1;
        idle(1);
        chk("ovr_popped", 32'(data_valid), 32'd0);

        // back-to-back 4'h5, 4'hA with ready only in the completion cycle of 4'hA
        data_ready = 1'b0;
        send_word(4'h5, 0, 1'b0, 1'b0);
        send_word(4'hA, 0, 1'b0, 1'b1);
        idle(1);
        data_ready = 1'b0;
        chk("b2b_data", 32'(data_out), 32'hA);
        chk("b2b_valid", 32'(data_valid), 32'd1);
        chk("b2b_no_ovr", 32'(overrun), 32'd0);
        data_ready = 1'b1;
        idle(2);

        // frame_start after 2 bits restarts as 4'hE
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        chk("ferr_pulse", 32'(frame_err), 32'd1);
        send_bit(1'b0, 1'b1);
        chk("ferr_one_cycle", 32'(frame_err), 32'd0);
        send_bit(1'b0, 1'b0);
`ifdef SIPO_DEFRAMER_PARITY_EN
        send_bit(1'b0, 1'b1);
`endif
        idle(1);
        chk("ferr_data", 32'(data_out), 32'hE);
        idle(2);

`ifdef SIPO_DEFRAMER_PARITY_EN
        send_word(4'h7, 0, 1'b1, 1'b0);
        idle(1);
        chk("par_good", 32'(parity_err_w), 32'd0);
        chk("par_good_data", 32'(data_out), 32'h7);
        idle(1);
        send_word(4'h7, 0, 1'b0, 1'b0);
        idle(1);
        chk("par_bad", 32'(parity_err_w), 32'd1);
        idle(2);
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i == 1500) rst = 1'b0;
            if (i == 1502) rst = 1'b1;
            bit_valid   = ($urandom_range(0, 3) != 0);
            frame_start = m_in_frame ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) != 0);
            serial_in   = 1'($urandom_range(0, 1));
            data_ready  = ($urandom_range(0, 2) != 0);
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
